// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding and datapath width.
package muldiv_unit_pkg;

   localparam int XLEN = 32;
   localparam int ITER = 32;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step.
// Zero latency; no flow control, the caller decides when to register the result.
module muldiv_step
   import muldiv_unit_pkg::*;
(
   input  logic            is_div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic          ge;

   always_comb begin
      sum     = {1'b0, hi_i} + {1'b0, (lo_i[0] ? b_i : {XLEN{1'b0}})};
      shifted = {hi_i, lo_i[XLEN-1]};
      ge      = (shifted >= {1'b0, b_i});
      if (is_div_i) begin
         // The difference is below 2^XLEN whenever ge holds, so a narrow subtract suffices.
         hi_o = ge ? (shifted[XLEN-1:0] - b_i) : shifted[XLEN-1:0];
         lo_o = {lo_i[XLEN-2:0], ge};
      end else begin
         hi_o = sum[XLEN:1];
         lo_o = {sum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with register-file style writeback.
// Latency 33 cycles (1 for divide special cases); start is ignored while busy.
module muldiv_unit #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic            write_enable,
   output logic [4:0]      rd_out,
   output logic [XLEN-1:0] result
);
   import muldiv_unit_pkg::*;

   localparam int CW = $clog2(ITER);
   localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [4:0]      rd_lat_q, rd_lat_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic            neg_res_q, neg_res_d;
   logic            neg_rem_q, neg_rem_d;
   logic            spec_q, spec_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [4:0]      rd_out_q, rd_out_d;

   logic            accept;
   logic            s1, s2, neg1, neg2;
   logic [XLEN-1:0] mag1, mag2;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] spec_val;
   logic [XLEN-1:0] step_hi, step_lo;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0] quo_s, rem_s, fix_val;

   assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   // Operand conditioning: magnitudes, sign flags and early-exit results.
   always_comb begin
      s1   = (funct3 == OP_MUL) || (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
             (funct3 == OP_DIV) || (funct3 == OP_REM);
      s2   = (funct3 == OP_MUL) || (funct3 == OP_MULH) ||
             (funct3 == OP_DIV) || (funct3 == OP_REM);
      neg1 = s1 && rs1_data[XLEN-1];
      neg2 = s2 && rs2_data[XLEN-1];
      mag1 = neg1 ? (~rs1_data + 1'b1) : rs1_data;
      mag2 = neg2 ? (~rs2_data + 1'b1) : rs2_data;
      div_zero = funct3[2] && (rs2_data == '0);
      div_ovf  = funct3[2] && !funct3[0] &&
                 (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == {XLEN{1'b1}});
      special  = div_zero || div_ovf;
      if (div_zero)
         spec_val = funct3[1] ? rs1_data : {XLEN{1'b1}};
      else
         spec_val = funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
   end

   muldiv_step u_step (
      .is_div_i (funct3_q[2]),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .b_i      (b_q),
      .hi_o     (step_hi),
      .lo_o     (step_lo)
   );

   // Sign fix-up and result selection; special cases carry their answer in lo_q.
   always_comb begin
      prod_s = neg_res_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
      quo_s  = neg_res_q ? (~lo_q + 1'b1) : lo_q;
      rem_s  = neg_rem_q ? (~hi_q + 1'b1) : hi_q;
      if (spec_q)
         fix_val = lo_q;
      else if (funct3_q == OP_MUL)
         fix_val = prod_s[XLEN-1:0];
      else if (!funct3_q[2])
         fix_val = prod_s[2*XLEN-1:XLEN];
      else if (!funct3_q[1])
         fix_val = quo_s;
      else
         fix_val = rem_s;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = special ? S_FIX : S_CALC;
         S_CALC:  if (cnt_q == CNT_LAST) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = accept ? (special ? S_FIX : S_CALC) : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_CALC) || (state_q == S_FIX);
      done = (state_q == S_DONE);
      write_enable = done;
   end

   always_comb begin
      cnt_d     = cnt_q;
      funct3_d  = funct3_q;
      rd_lat_d  = rd_lat_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      b_d       = b_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      spec_d    = spec_q;
      result_d  = result_q;
      rd_out_d  = rd_out_q;
      if (accept) begin
         cnt_d     = '0;
         funct3_d  = funct3;
         rd_lat_d  = rd_in;
         hi_d      = '0;
         lo_d      = special ? spec_val : mag1;
         b_d       = mag2;
         neg_res_d = neg1 ^ neg2;
         neg_rem_d = neg1;
         spec_d    = special;
      end else if (state_q == S_CALC) begin
         cnt_d = cnt_q + 1'b1;
         hi_d  = step_hi;
         lo_d  = step_lo;
      end else if (state_q == S_FIX) begin
         result_d = fix_val;
         rd_out_d = rd_lat_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         funct3_q  <= '0;
         rd_lat_q  <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         b_q       <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         spec_q    <= 1'b0;
         result_q  <= '0;
         rd_out_q  <= '0;
      end else begin
         cnt_q     <= cnt_d;
         funct3_q  <= funct3_d;
         rd_lat_q  <= rd_lat_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         b_q       <= b_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         spec_q    <= spec_d;
         result_q  <= result_d;
         rd_out_q  <= rd_out_d;
      end
   end

   assign result = result_q;
   assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues expected writebacks,
// a negedge monitor pops and compares them whenever done is presented.
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic        write_enable;
   logic [4:0]  rd_out;
   logic [31:0] result;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] res;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_done = 0;
   int   cyc = 0;

   muldiv_unit #(.XLEN(32), .ITER(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .funct3       (funct3),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .rd_in        (rd_in),
      .busy         (busy),
      .done         (done),
      .write_enable (write_enable),
      .rd_out       (rd_out),
      .result       (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (done) begin
         n_done++;
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: done=1 with no request outstanding (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", result, e.res);
            check("rd_out", 32'(rd_out), 32'(e.rd));
            check("write_enable", 32'(write_enable), 32'd1);
            check("latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input int lat);
      funct3   = f;
      rs1_data = a;
      rs2_data = b;
      rd_in    = rd;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      rs1_data = 32'hDEAD_BEEF;
      rs2_data = 32'h1234_5678;
      rd_in    = 5'd31;
      sb.push_back('{rd, res, cyc + lat});
   endtask

   task automatic wait_done(output int bc);
      bit seen;
      bc   = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (busy) bc++;
      end
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: no done within 100 cycles (cycle %0d)", cyc);
      end
   endtask

   task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                        input int lat);
      int bc;
      issue(f, a, b, rd, res, lat);
      wait_done(bc);
      check({name, "_busy_cycles"}, 32'(bc), 32'(lat));
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int bc;
      int d0;
      reset    = 1'b1;
      start    = 1'b0;
      funct3   = 3'b000;
      rs1_data = '0;
      rs2_data = '0;
      rd_in    = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_we", 32'(write_enable), 32'd0);
      check("rst_rd_out", 32'(rd_out), 32'd0);
      check("rst_result", result, 32'd0);

      do_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
      do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33);
      do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33);
      do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33);
      do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        5'd9,  32'hFFFF_FFFD, 33);
      do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFF, 33);
      do_op("divu",   3'b101, 32'hFFFF_FFF9, 32'd2,        5'd11, 32'h7FFF_FFFC, 33);
      do_op("remu",   3'b111, 32'hFFFF_FFF9, 32'd2,        5'd12, 32'd1,        33);
      do_op("div0",   3'b100, 32'd5,        32'd0,        5'd13, 32'hFFFF_FFFF, 1);
      do_op("rem0",   3'b110, 32'd5,        32'd0,        5'd14, 32'd5,        1);
      do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
      do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,        1);

      // A start while busy must be dropped; an extra done would surface in the monitor.
      issue(3'b000, 32'd3, 32'd4, 5'd17, 32'd12, 33);
      repeat (5) @(posedge clk);
      #1;
      funct3   = 3'b101;
      rs1_data = 32'd100;
      rs2_data = 32'd10;
      rd_in    = 5'd18;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(bc);
      @(negedge clk);
      check("ignore_done_pulse", 32'(done), 32'd0);
      repeat (40) @(negedge clk);
      check("ignore_result_held", result, 32'd12);

      // Reset in the middle of CALC: the operation vanishes without a done.
      issue(3'b000, 32'd9, 32'd9, 5'd19, 32'd81, 33);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      void'(sb.pop_back());
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_rd_out", 32'(rd_out), 32'd0);
      d0 = n_done;
      repeat (40) @(negedge clk);
      check("midrst_no_done", 32'(n_done), 32'(d0));

      // Back-to-back: second start lands in the DONE cycle of the first.
      issue(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd20, 32'h7FFF_FFFC, 33);
      wait_done(bc);
      issue(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd21, 32'd1, 33);
      repeat (16) @(negedge clk);
      check("b2b_result_held", result, 32'h7FFF_FFFC);
      check("b2b_rd_held", 32'(rd_out), 32'd20);
      check("b2b_busy", 32'(busy), 32'd1);
      wait_done(bc);
      @(negedge clk);
      check("b2b_done_pulse", 32'(done), 32'd0);
      check("b2b_result_after", result, 32'd1);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
